butterfly_stage_scheduler: RTL

// - Sequences one in-place radix-2 FFT/NTT transform over N=2^LOGN points held in two parity-interleaved BRAM banks.
// - Issues one butterfly per cycle: read addresses for both operands, twiddle index, and destination bank/address/valid tags.
// - The downstream store logic delays the tags to match the butterfly latency.
// - Inserts a pipeline-drain gap between stages so no stage reads data the previous stage has not yet written.

---
 rtl/butterfly_stage_scheduler_if.sv | 47 ++++
 rtl/butterfly_stage_scheduler.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/butterfly_stage_scheduler_if.sv
// Issue-side bus of the radix-2 butterfly scheduler.
// The stall input exists only when SCHED_STALL_EN is defined.
interface butterfly_stage_scheduler_if #(
  parameter int unsigned LOGN       = 12,
  parameter int unsigned ADDR_WIDTH = 11
);
  localparam int unsigned SW = $clog2(LOGN + 1);

  logic                  start;
  logic                  is_fft;
  logic                  is_dif;
`ifdef SCHED_STALL_EN
  logic                  stall;
`endif
  logic                  busy;
  logic                  done;
  logic [SW-1:0]         stage;
  logic                  rd_valid;
  logic [ADDR_WIDTH-1:0] rd_addr_a;
  logic [ADDR_WIDTH-1:0] rd_addr_b;
  logic                  rd_bank_a;
  logic [LOGN-2:0]       tw_idx;
  logic                  dest_bank_a;
  logic                  dest_bank_b;
  logic [ADDR_WIDTH-1:0] dest_addr_a;
  logic [ADDR_WIDTH-1:0] dest_addr_b;
  logic                  valid_a;
  logic                  valid_b;

  modport master (
    output start, is_fft, is_dif,
`ifdef SCHED_STALL_EN
    output stall,
`endif
    input  busy, done, stage, rd_valid, rd_addr_a, rd_addr_b, rd_bank_a, tw_idx,
    input  dest_bank_a, dest_bank_b, dest_addr_a, dest_addr_b, valid_a, valid_b
  );

  modport slave (
    input  start, is_fft, is_dif,
`ifdef SCHED_STALL_EN
    input  stall,
`endif
    output busy, done, stage, rd_valid, rd_addr_a, rd_addr_b, rd_bank_a, tw_idx,
    output dest_bank_a, dest_bank_b, dest_addr_a, dest_addr_b, valid_a, valid_b
  );
endinterface

// File: rtl/butterfly_stage_scheduler.sv
// Sequences one in-place radix-2 FFT/NTT over two parity-interleaved banks, one butterfly per cycle.
// Optional macro SCHED_STALL_EN adds a stall input that freezes issue and drain counting.
module butterfly_stage_scheduler #(
  parameter int unsigned LOGN       = 12,
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned FFT_DRAIN  = 24,
  parameter int unsigned NTT_DRAIN  = 22
) (
  input  logic                        clk,
  input  logic                        rst_n,
  butterfly_stage_scheduler_if.slave  bus
);

  localparam int unsigned SW   = $clog2(LOGN + 1);
  localparam int unsigned JW   = LOGN - 1;
  localparam int unsigned DMAX = (FFT_DRAIN > NTT_DRAIN) ? FFT_DRAIN : NTT_DRAIN;
  localparam int unsigned CW   = (DMAX > 1) ? $clog2(DMAX) : 1;
  localparam logic [JW-1:0] J_LAST = '1;
  localparam logic [SW-1:0] S_LAST = SW'(LOGN - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic                  bank_a;
    logic                  bank_b;
    logic [JW-1:0]         tw;
  } bfly_t;

  state_t        state;
  logic [JW-1:0] j;
  logic [CW-1:0] cnt;
  logic [SW-1:0] stage_q;
  logic          fft_q, dif_q, busy_q, done_q, valid_q;
  bfly_t         bf_q, bf_c;
  logic          stall_c;
  logic [SW-1:0] sel_stage_c;
  logic [JW-1:0] sel_j_c;
  logic          sel_dif_c;
  logic          drain_en_c;
  logic [CW-1:0] drain_last_c;

`ifdef SCHED_STALL_EN
  assign stall_c = bus.stall;
`else
  assign stall_c = 1'b0;
`endif

  // Operand pair, banks and twiddle for butterfly jj of stage s.
  function automatic bfly_t calc(input logic [SW-1:0] s, input logic [JW-1:0] jj, input logic dif);
    logic [SW-1:0]   lh;
    logic [LOGN-1:0] hm, i0, i1;
    bfly_t           r;
    lh       = dif ? (S_LAST - s) : s;
    hm       = (LOGN'(1) << lh) - LOGN'(1);
    i0       = ((LOGN'(jj) >> lh) << (lh + SW'(1))) | (LOGN'(jj) & hm);
    i1       = i0 | (LOGN'(1) << lh);
    r.addr_a = ADDR_WIDTH'(i0 >> 1);
    r.addr_b = ADDR_WIDTH'(i1 >> 1);
    r.bank_a = ^i0;
    r.bank_b = ^i1;
    r.tw     = JW'((LOGN'(jj) & hm) << (S_LAST - lh));
    return r;
  endfunction

  // Drain length of the latched transform type; a zero drain chains stages directly.
  always_comb begin
    drain_en_c   = fft_q ? (FFT_DRAIN != 0) : (NTT_DRAIN != 0);
    drain_last_c = fft_q ? (CW'(FFT_DRAIN) - CW'(1)) : (CW'(NTT_DRAIN) - CW'(1));
  end

  // Butterfly that would be issued at the coming edge, if the FSM issues one.
  always_comb begin
    sel_stage_c = stage_q + 1'b1;
    sel_j_c     = '0;
    sel_dif_c   = dif_q;
    if (state == IDLE) begin
      sel_stage_c = '0;
      sel_dif_c   = bus.is_dif;
    end else if (state == ISSUE && j != J_LAST) begin
      sel_stage_c = stage_q;
      sel_j_c     = j + 1'b1;
    end
    bf_c = calc(sel_stage_c, sel_j_c, sel_dif_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      j       <= '0;
      cnt     <= '0;
      stage_q <= '0;
      fft_q   <= 1'b0;
      dif_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      bf_q    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: if (bus.start) begin
          state   <= ISSUE;
          busy_q  <= 1'b1;
          fft_q   <= bus.is_fft;
          dif_q   <= bus.is_dif;
          j       <= '0;
          stage_q <= '0;
          bf_q    <= bf_c;
          valid_q <= 1'b1;
        end
        ISSUE: begin
          if (stall_c) begin
            valid_q <= 1'b0;
          end else if (j != J_LAST) begin
            j       <= j + 1'b1;
            bf_q    <= bf_c;
            valid_q <= 1'b1;
          end else if (drain_en_c) begin
            state   <= DRAIN;
            cnt     <= '0;
            valid_q <= 1'b0;
          end else if (stage_q != S_LAST) begin
            stage_q <= stage_q + 1'b1;
            j       <= '0;
            bf_q    <= bf_c;
            valid_q <= 1'b1;
          end else begin
            state   <= DONE;
            done_q  <= 1'b1;
            valid_q <= 1'b0;
          end
        end
        DRAIN: if (!stall_c) begin
          if (cnt != drain_last_c) begin
            cnt <= cnt + 1'b1;
          end else if (stage_q != S_LAST) begin
            state   <= ISSUE;
            stage_q <= stage_q + 1'b1;
            j       <= '0;
            bf_q    <= bf_c;
            valid_q <= 1'b1;
          end else begin
            state  <= DONE;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          state   <= IDLE;
          busy_q  <= 1'b0;
          stage_q <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // In-place update: destinations mirror the read side.
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.stage       = stage_q;
  assign bus.rd_valid    = valid_q;
  assign bus.valid_a     = valid_q;
  assign bus.valid_b     = valid_q;
  assign bus.rd_addr_a   = bf_q.addr_a;
  assign bus.rd_addr_b   = bf_q.addr_b;
  assign bus.dest_addr_a = bf_q.addr_a;
  assign bus.dest_addr_b = bf_q.addr_b;
  assign bus.rd_bank_a   = bf_q.bank_a;
  assign bus.dest_bank_a = bf_q.bank_a;
  assign bus.dest_bank_b = bf_q.bank_b;
  assign bus.tw_idx      = bf_q.tw;

endmodule
